// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer requests, FIFO write port and arbiter status flags.
// The master modport is the producer/FIFO side; the slave modport is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int W = 3
) ();
    logic         req0;
    logic         req1;
    logic [W-1:0] din0;
    logic [W-1:0] din1;
    logic         full;
    logic         clr_ovr;
    logic         wr;
    logic [W-1:0] wdata;
    logic         ack0;
    logic         ack1;
    logic [1:0]   pend;
    logic [1:0]   overrun;
    logic         last_grant;

    modport master (
        output req0, req1, din0, din1, full, clr_ovr,
        input  wr, wdata, ack0, ack1, pend, overrun, last_grant
    );

    modport slave (
        input  req0, req1, din0, din1, full, clr_ovr,
        output wr, wdata, ack0, ack1, pend, overrun, last_grant
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers.
// Each producer owns a one-entry slot; writes are paced to one per two cycles.
module fifo_wr_arbiter #(
    parameter int W = 3
) (
    input  logic             clk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus
);
    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         issue;
    logic         sel;
    logic         grant0;
    logic         grant1;

    // Requiring wr=0 leaves a cycle for full to reflect the previous write.
    always_comb begin
        issue = (bus.pend != 2'b00) && !bus.full && !bus.wr;
        case (bus.pend)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~bus.last_grant;
            default: sel = 1'b0;
        endcase
        grant0 = issue & ~sel;
        grant1 = issue & sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wr         <= 1'b0;
            bus.wdata      <= '0;
            bus.ack0       <= 1'b0;
            bus.ack1       <= 1'b0;
            bus.pend       <= '0;
            bus.overrun    <= '0;
            bus.last_grant <= 1'b1;
            slot0          <= '0;
            slot1          <= '0;
        end else begin
            bus.wr   <= issue;
            bus.ack0 <= grant0;
            bus.ack1 <= grant1;
            if (issue) begin
                bus.wdata      <= sel ? slot1 : slot0;
                bus.last_grant <= sel;
            end

            // A slot being granted this edge is free to accept a new request.
            if (bus.req0 && (!bus.pend[0] || grant0)) begin
                bus.pend[0] <= 1'b1;
                slot0       <= bus.din0;
            end else if (grant0) begin
                bus.pend[0] <= 1'b0;
            end

            if (bus.req1 && (!bus.pend[1] || grant1)) begin
                bus.pend[1] <= 1'b1;
                slot1       <= bus.din1;
            end else if (grant1) begin
                bus.pend[1] <= 1'b0;
            end

            bus.overrun[0] <= (bus.req0 & bus.pend[0] & ~grant0) | (bus.overrun[0] & ~bus.clr_ovr);
            bus.overrun[1] <= (bus.req1 & bus.pend[1] & ~grant1) | (bus.overrun[1] & ~bus.clr_ovr);
        end
    end
endmodule
